// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single memory request port between the instruction-fetch unit
// (IFU) and the load/store unit (LSU). Only one transaction is outstanding at
// a time: a requester is granted in IDLE, its request is latched and presented
// to memory with a valid/ready handshake, and the memory response is routed
// back to the requester that owns the transaction.
//
// Optional build macro:
//   ARB_RR_EN  - when defined, simultaneous requests alternate between IFU and
//                LSU (round-robin). When undefined, LSU has fixed priority.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   ifu_req_valid/ready, ifu_addr             IFU read request channel
//   ifu_resp_valid, ifu_rdata                 IFU response (1-cycle pulse, data held)
//   lsu_req_valid/ready, lsu_addr, lsu_wen,
//   lsu_wdata, lsu_wmask                      LSU request channel
//   lsu_resp_valid, lsu_rdata                 LSU response (1-cycle pulse, data held)
//   mem_req_valid/ready, mem_addr, mem_wen,
//   mem_wdata, mem_wmask                      latched request toward memory
//   mem_resp_valid, mem_rdata                 memory response strobe and data
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    ifu_req_valid,
   output logic                    ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]   ifu_addr,
   output logic                    ifu_resp_valid,
   output logic [DATA_WIDTH-1:0]   ifu_rdata,

   input  logic                    lsu_req_valid,
   output logic                    lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr,
   input  logic                    lsu_wen,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
   output logic                    lsu_resp_valid,
   output logic [DATA_WIDTH-1:0]   lsu_rdata,

   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_wen,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wmask,
   input  logic                    mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   // state   | meaning
   // IDLE    | no transaction; grant a requester if any is valid
   // REQ     | latched request presented to memory, waiting for mem_req_ready
   // RESP    | request accepted, waiting for mem_resp_valid
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   logic [1:0] state;
   logic       owner;
   logic       grant_any;
   logic       grant_lsu;

`ifdef ARB_RR_EN
   logic       last_grant;
`endif

   always_comb begin
      grant_any = (state == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
`ifdef ARB_RR_EN
      // On a tie, hand the port to whoever did not win last time.
      if (ifu_req_valid && lsu_req_valid)
         grant_lsu = (last_grant == OWN_IFU);
      else
         grant_lsu = lsu_req_valid;
`else
      grant_lsu = lsu_req_valid;
`endif
   end

   assign ifu_req_ready = grant_any && !grant_lsu;
   assign lsu_req_ready = grant_any && grant_lsu;
   assign mem_req_valid = (state == ST_REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         owner          <= OWN_IFU;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_rdata      <= '0;
         lsu_rdata      <= '0;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  owner <= grant_lsu;
                  // IFU fetches are always plain reads with no write payload.
                  if (grant_lsu) begin
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
                  state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_req_ready)
                  state <= ST_RESP;
            end
            ST_RESP: begin
               if (mem_resp_valid) begin
                  if (owner == OWN_IFU) begin
                     ifu_rdata      <= mem_rdata;
                     ifu_resp_valid <= 1'b1;
                  end else begin
                     // A completed write leaves the last read data visible.
                     if (!mem_wen)
                        lsu_rdata <= mem_rdata;
                     lsu_resp_valid <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= OWN_LSU;
      else if (grant_any)
         last_grant <= grant_lsu;
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter: a directed vector table (ties, single
// reads/writes, backpressure, spurious responses), a hand-written reset-in-
// flight sequence, and randomized transactions checked against a
// transaction-level reference model. Honours ARB_RR_EN for tie expectations.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [3:0]    lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [3:0]    mem_wmask;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv, lv;
      logic [AW-1:0] ia, la;
      logic          wen;
      logic [DW-1:0] wd;
      logic [3:0]    wm;
      logic [DW-1:0] rd;
      int            wait_c, delay_c;
      bit            spur;
      bit            exp_lsu;
      logic [AW-1:0] e_addr;
      logic          e_wen;
      logic [DW-1:0] e_wdata;
      logic [3:0]    e_wmask;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   logic [DW-1:0] m_ifu_rdata, m_lsu_rdata;
   bit            m_last_lsu;
   bit            pend_ifu, pend_lsu;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      m_ifu_rdata = '0;
      m_lsu_rdata = '0;
      m_last_lsu  = 1'b1;
      pend_ifu    = 1'b0;
      pend_lsu    = 1'b0;
   endtask

   // Checks the response pulse expected from the previous transaction (if any)
   // and the held read data; clears the pending pulse afterwards.
   task automatic check_resp(input string name);
      chk({name, ".ifu_resp_valid"}, ifu_resp_valid, pend_ifu);
      chk({name, ".lsu_resp_valid"}, lsu_resp_valid, pend_lsu);
      chk({name, ".ifu_rdata"}, ifu_rdata, m_ifu_rdata);
      chk({name, ".lsu_rdata"}, lsu_rdata, m_lsu_rdata);
      pend_ifu = 1'b0;
      pend_lsu = 1'b0;
   endtask

   task automatic check_mem_fields(input string name, input vec_t v);
      chk({name, ".mem_addr"}, mem_addr, v.e_addr);
      chk({name, ".mem_wen"}, mem_wen, v.e_wen);
      chk({name, ".mem_wdata"}, mem_wdata, v.e_wdata);
      chk({name, ".mem_wmask"}, mem_wmask, v.e_wmask);
   endtask

   task automatic busy_inputs();
      ifu_req_valid = 1'($urandom_range(0, 1));
      lsu_req_valid = 1'($urandom_range(0, 1));
      ifu_addr      = $urandom;
      lsu_addr      = $urandom;
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom);
      lsu_wen       = 1'($urandom_range(0, 1));
   endtask

   // One complete transaction. Entered and left #1 after a rising edge with the
   // DUT idle; the response pulse is checked in the next cycle by check_resp.
   task automatic do_txn(input string name, input vec_t v);
      ifu_req_valid  = v.iv;
      lsu_req_valid  = v.lv;
      ifu_addr       = v.ia;
      lsu_addr       = v.la;
      lsu_wen        = v.wen;
      lsu_wdata      = v.wd;
      lsu_wmask      = v.wm;
      mem_req_ready  = 1'b0;
      mem_resp_valid = v.spur;
      @(negedge clk);
      chk({name, ".ifu_req_ready"}, ifu_req_ready, !v.exp_lsu);
      chk({name, ".lsu_req_ready"}, lsu_req_ready, v.exp_lsu);
      chk({name, ".idle_mem_req_valid"}, mem_req_valid, 1'b0);
      check_resp({name, ".prev"});
      @(posedge clk); #1;
      busy_inputs();
      for (int w = 0; w < v.wait_c; w++) begin
         mem_req_ready  = 1'b0;
         mem_resp_valid = v.spur;
         @(negedge clk);
         chk({name, ".stall_mem_req_valid"}, mem_req_valid, 1'b1);
         chk({name, ".stall_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
         chk({name, ".stall_resp"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
         check_mem_fields({name, ".stall"}, v);
         @(posedge clk); #1;
         busy_inputs();
      end
      mem_req_ready  = 1'b1;
      mem_resp_valid = v.spur;
      @(negedge clk);
      chk({name, ".acc_mem_req_valid"}, mem_req_valid, 1'b1);
      chk({name, ".acc_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk({name, ".acc_resp"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      check_mem_fields({name, ".acc"}, v);
      @(posedge clk); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      busy_inputs();
      for (int d = 0; d < v.delay_c; d++) begin
         @(negedge clk);
         chk({name, ".wait_mem_req_valid"}, mem_req_valid, 1'b0);
         chk({name, ".wait_resp"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
         @(posedge clk); #1;
         busy_inputs();
      end
      mem_resp_valid = 1'b1;
      mem_rdata      = v.rd;
      @(negedge clk);
      chk({name, ".resp_mem_req_valid"}, mem_req_valid, 1'b0);
      chk({name, ".resp_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      ifu_req_valid  = 1'b0;
      lsu_req_valid  = 1'b0;
      // model: route response to the owner; LSU writes keep prior read data
      if (!v.exp_lsu) begin
         m_ifu_rdata = v.rd;
         pend_ifu    = 1'b1;
      end else begin
         if (!v.wen) m_lsu_rdata = v.rd;
         pend_lsu = 1'b1;
      end
      m_last_lsu = v.exp_lsu;
   endtask

   task automatic idle_cycle(input string name);
      ifu_req_valid  = 1'b0;
      lsu_req_valid  = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk({name, ".idle_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk({name, ".idle_mem_req_valid"}, mem_req_valid, 1'b0);
      check_resp(name);
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string name);
      chk({name, ".readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk({name, ".valids"}, {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
      chk({name, ".rdata"}, {ifu_rdata, lsu_rdata}, 64'h0);
      chk({name, ".mem_addr"}, mem_addr, 0);
      chk({name, ".mem_w"}, {mem_wen, mem_wmask, mem_wdata}, 37'h0);
   endtask

   // Build a vector whose expectations follow from the grant decision.
   function automatic vec_t mk(input logic iv, lv, input logic [AW-1:0] ia, la,
                               input logic wen, input logic [DW-1:0] wd,
                               input logic [3:0] wm, input logic [DW-1:0] rd,
                               input int wc, dc, input bit spur, input bit exp_lsu);
      vec_t v;
      v.iv = iv; v.lv = lv; v.ia = ia; v.la = la; v.wen = wen; v.wd = wd;
      v.wm = wm; v.rd = rd; v.wait_c = wc; v.delay_c = dc; v.spur = spur;
      v.exp_lsu = exp_lsu;
      v.e_addr  = exp_lsu ? la : ia;
      v.e_wen   = exp_lsu ? wen : 1'b0;
      v.e_wdata = exp_lsu ? wd : '0;
      v.e_wmask = exp_lsu ? wm : 4'h0;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[9];

   initial begin
      vec_t v;
      bit   el;

      // ties right after reset: fixed LSU priority, or IFU-first alternation
      for (int i = 0; i < 4; i++)
         tbl[i] = mk(1, 1, 32'h1000_0000 + 32'(i * 4), 32'h2000_0000, 1, 32'h1111_1111,
                     4'h3, 32'hA0 + 32'(i), 0, 0, 0, RR ? (i % 2 == 1) : 1'b1);
      tbl[4] = mk(1, 0, 32'h8000_0000, 32'h4444_0000, 1, 32'hCAFE_F00D, 4'hF,
                  32'h0000_0013, 0, 0, 0, 0);
      tbl[5] = mk(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF,
                  32'h5555_5555, 0, 0, 0, 1);
      tbl[6] = mk(0, 1, 32'h0, 32'h8000_2000, 0, 32'h1234_5678, 4'h5,
                  32'hABCD_0001, 0, 1, 0, 1);
      tbl[7] = mk(1, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 4'h0,
                  32'h0000_0077, 5, 2, 0, 0);
      tbl[8] = mk(0, 1, 32'h0, 32'h8000_3000, 0, 32'h0, 4'h0,
                  32'h0000_0099, 1, 3, 1, 1);

      rst = 1'b1;
      ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = 0; lsu_addr = 0;
      lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      idle_cycle("post_reset");

      // directed table
      for (int i = 0; i < 9; i++)
         do_txn($sformatf("vec%0d", i), tbl[i]);
      idle_cycle("vec_end");

      // reset while waiting for a response
      ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
      @(posedge clk); #1;
      ifu_req_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      @(negedge clk);
      chk("rst_mid.pre_mem_addr", mem_addr, 32'h8000_0100);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all_zero("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      @(posedge clk); #1;
      mem_resp_valid = 0;
      idle_cycle("rst_mid.late_resp");
      do_txn("rst_mid.next_ifu", mk(1, 0, 32'h8000_0200, 32'h0, 0, 32'h0, 4'h0,
                                     32'h0000_0042, 0, 0, 0, 0));

      // randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         logic iv, lv;
         iv = 1'($urandom_range(0, 1));
         lv = 1'($urandom_range(0, 1));
         if (!iv && !lv) iv = 1'b1;
         if (iv && lv) el = RR ? !m_last_lsu : 1'b1;
         else          el = lv;
         v = mk(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), el);
         do_txn($sformatf("rand%0d", n), v);
      end
      idle_cycle("rand_end");
      idle_cycle("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
